wr_addr_generator: RTL and testbench
====================================

WR_ADDR_GENERATOR -- requirements
Module: wr_addr_generator

Interface
REQ-001 SHALL have parameter stage_FFT, default 2, meaning current radix-2 DIT stage number (1-based, >=2); half-span H = 2^(stage_FFT-1).
REQ-002 SHALL have parameter N, default 16, meaning FFT length (power of two, N >= 2H).
REQ-003 SHALL have parameter SIZE, default 4, meaning log2(N), the memory address width.
REQ-004 SHALL have parameter WIDTH, default 32, meaning bit width of one packed complex sample.
REQ-005 SHALL have ports, in this order:
- clk  input  1  sole clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_stage  input  1  one-cycle pulse that arms the block for one stage.
- in_valid  input  1  butterfly result pair present.
- in_top  input  WIDTH  butterfly top output (A+WB).
- in_bot  input  WIDTH  butterfly bottom output (A-WB).
- in_ready  output  1  pair accepted when in_valid and in_ready are both high.
- en_wr  output  1  memory write enable.
- wr_ptr  output  SIZE  memory write address.
- wr_data  output  WIDTH  memory write data.
- stage_done  output  1  one-cycle pulse at end of stage.

Function
REQ-006 SHALL accept exactly N/2 pairs per armed stage and issue exactly N memory writes, one per cycle at most, over a single write port.
REQ-007 SHALL number accepted pairs p = 0..N/2-1 and use k = p mod H and g = p div H.
REQ-008 SHALL write pair p's top word to address g*2H + k, then its bottom word to g*2H + k + H on the next cycle.
REQ-009 SHALL produce address order identical to the stage read sequence; for stage_FFT=2, N=16 that order is 0,2,1,3,4,6,5,7,...
REQ-010 SHALL buffer accepted pairs in a 2-entry FIFO; in_ready = armed AND FIFO not full AND accepted count < N/2.
REQ-011 SHALL use FSM states IDLE, WAIT, WRITE_1, WRITE_2, DONE with these transitions:
- IDLE -> WAIT on start_stage.
- WAIT -> WRITE_1 when the FIFO is non-empty.
- WRITE_1 -> WRITE_2 unconditionally.
- WRITE_2 -> DONE after pair N/2-1.
- WRITE_2 -> WRITE_1 if the FIFO is non-empty.
- WRITE_2 -> WAIT otherwise.
- DONE -> IDLE.
REQ-012 SHALL pop the FIFO head on entering WRITE_1.
REQ-013 SHALL assert en_wr with the top word in WRITE_1 and with the bottom word in WRITE_2.
REQ-014 SHALL give a minimum latency of 1 cycle from handshake to top write, and bottom write 1 cycle after top write.
REQ-015 SHALL sustain one pair per 2 cycles with no bubble when pairs arrive continuously.
REQ-016 SHALL handle an accept and a pop in the same cycle with the FIFO occupancy unchanged.
REQ-017 SHALL pulse stage_done for exactly one cycle, in DONE, the cycle after the final bottom write (address N-1 for the last stage).
REQ-018 SHALL ignore start_stage outside IDLE.
REQ-019 SHALL hold in_ready low in IDLE and DONE; in_valid in those states SHALL be ignored and not stored.
REQ-020 SHALL compute addresses modulo 2^SIZE with no overflow, since g*2H + k + H <= N-1 by construction.
REQ-021 SHALL drive wr_ptr and wr_data to 0 whenever en_wr is low.

Reset
REQ-022 SHALL, while rst is high, set state to IDLE; en_wr, in_ready, stage_done, wr_ptr, wr_data and all counters to 0; and flush the FIFO.
REQ-023 SHALL abort an in-progress stage when rst is asserted mid-stage, with no further writes until a new start_stage.

Structure
REQ-024 SHALL place FSM state encodings and H/span helper functions in shared package fft_pkg.
REQ-025 SHALL implement the buffer as sub-module pair_fifo (depth 2, width 2*WIDTH, synchronous active-high reset).

Verification
REQ-026 SHALL cover: stage_FFT=2, N=16, one pair every 2 cycles -> wr_ptr sequence 0,2,1,3,4,6,5,7,8,10,9,11,12,14,13,15, with 16 writes and stage_done once.
REQ-027 SHALL cover: stage_FFT=4, N=16 -> wr_ptr sequence 0,8,1,9,...,7,15, with the top/bottom data pairing preserved.
REQ-028 SHALL cover: in_valid held high every cycle -> in_ready deasserts with 2 pairs pending, no pair is lost or duplicated, and 8 pairs complete.
REQ-029 SHALL cover: pairs spaced 5 cycles apart -> FSM passes through WAIT, and each top write occurs 1 cycle after its handshake.
REQ-030 SHALL cover: rst pulsed after pair 3 -> en_wr low the next cycle, then a fresh start_stage restarts at address 0.
REQ-031 SHALL cover: start_stage pulsed mid-stage, and in_valid pulsed in IDLE -> both ignored, with the write count unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FSM encodings and address helpers for the FFT write path
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        WRITE_1 = 3'd2,
        WRITE_2 = 3'd3,
        DONE    = 3'd4
    } wr_state_t;

    function automatic int unsigned half_span(input int unsigned stage);
        return 32'd1 << (stage - 1);
    endfunction

    function automatic int unsigned span(input int unsigned stage);
        return 32'd1 << stage;
    endfunction

    // Top-word address of pair p: group base (p div H) * 2H plus offset p mod H.
    function automatic int unsigned top_address(input int unsigned p, input int unsigned stage);
        return ((p >> (stage - 1)) * span(stage)) | (p & (half_span(stage) - 1));
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - two-entry FIFO holding butterfly result pairs
module pair_fifo #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] mem [2];
    logic          wr_idx;
    logic          rd_idx;
    logic [1:0]    count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign head    = mem[rd_idx];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
        end else begin
            if (do_push) wr_idx <= !wr_idx;
            if (do_pop)  rd_idx <= !rd_idx;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/wr_addr_generator.sv
// rtl/wr_addr_generator.sv - serialises butterfly pairs into in-place FFT memory writes
module wr_addr_generator
    import fft_pkg::*;
#(
    parameter int stage_FFT = 2,
    parameter int N         = 16,
    parameter int SIZE      = 4,
    parameter int WIDTH     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stage,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_top,
    input  logic [WIDTH-1:0] in_bot,
    output logic             in_ready,
    output logic             en_wr,
    output logic [SIZE-1:0]  wr_ptr,
    output logic [WIDTH-1:0] wr_data,
    output logic             stage_done
);

    localparam int unsigned     H     = half_span(stage_FFT);
    localparam logic [SIZE-1:0] PAIRS = SIZE'(N / 2);

    wr_state_t          state;
    wr_state_t          state_n;
    logic [SIZE-1:0]    acc_cnt;
    logic [SIZE-1:0]    wr_cnt;
    logic [SIZE-1:0]    top_addr;
    logic [2*WIDTH-1:0] fifo_head;
    logic [2*WIDTH-1:0] head_pair;
    logic [WIDTH-1:0]   bot_hold;
    logic               fifo_empty;
    logic               fifo_full;
    logic               armed;
    logic               push;
    logic               avail;
    logic               take;
    logic               fifo_push;
    logic               fifo_pop;

    assign armed      = (state == WAIT) || (state == WRITE_1) || (state == WRITE_2);
    assign in_ready   = armed && !fifo_full && (acc_cnt < PAIRS);
    assign push       = in_valid && in_ready;
    assign avail      = !fifo_empty || push;
    assign take       = (state_n == WRITE_1);
    // An empty FIFO lets the incoming pair bypass straight into WRITE_1 for 1-cycle latency.
    assign head_pair  = fifo_empty ? {in_top, in_bot} : fifo_head;
    assign fifo_push  = push && !(fifo_empty && take);
    assign fifo_pop   = take && !fifo_empty;
    assign top_addr   = SIZE'(top_address(32'(wr_cnt), stage_FFT));
    assign stage_done = (state == DONE);

    pair_fifo #(.DW(2 * WIDTH)) u_pair_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({in_top, in_bot}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_stage) state_n = WAIT;
            WAIT:    if (avail) state_n = WRITE_1;
            WRITE_1: state_n = WRITE_2;
            WRITE_2: begin
                if (wr_cnt == PAIRS) state_n = DONE;
                else if (avail)      state_n = WRITE_1;
                else                 state_n = WAIT;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            bot_hold <= '0;
            en_wr    <= 1'b0;
            wr_ptr   <= '0;
            wr_data  <= '0;
        end else begin
            state   <= state_n;
            en_wr   <= 1'b0;
            wr_ptr  <= '0;
            wr_data <= '0;
            if (state == IDLE && start_stage) begin
                acc_cnt <= '0;
                wr_cnt  <= '0;
            end else begin
                if (push)             acc_cnt <= acc_cnt + SIZE'(1);
                if (state == WRITE_1) wr_cnt  <= wr_cnt + SIZE'(1);
            end
            // wr_cnt advances while leaving WRITE_1, so both words of a pair see the same index.
            if (take) begin
                en_wr    <= 1'b1;
                wr_ptr   <= top_addr;
                wr_data  <= head_pair[2*WIDTH-1:WIDTH];
                bot_hold <= head_pair[WIDTH-1:0];
            end else if (state == WRITE_1) begin
                en_wr   <= 1'b1;
                wr_ptr  <= top_addr + SIZE'(H);
                wr_data <= bot_hold;
            end
        end
    end

endmodule

// File: tb/tb_wr_addr_generator.sv
// tb/tb_wr_addr_generator.sv - randomized bench for wr_addr_generator at stages 2 and 4
module tb_wr_addr_generator;

    localparam int N     = 16;
    localparam int SIZE  = 4;
    localparam int WIDTH = 32;
    localparam int NP    = N / 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_stage;
    logic             in_valid;
    logic [WIDTH-1:0] in_top;
    logic [WIDTH-1:0] in_bot;
    logic             rdy_a, en_a, done_a;
    logic [SIZE-1:0]  ptr_a;
    logic [WIDTH-1:0] data_a;
    logic             rdy_b, en_b, done_b;
    logic [SIZE-1:0]  ptr_b;
    logic [WIDTH-1:0] data_b;

    always #5 clk = ~clk;

    wr_addr_generator #(.stage_FFT(2), .N(N), .SIZE(SIZE), .WIDTH(WIDTH)) dut_s2 (
        .clk(clk), .rst(rst), .start_stage(start_stage), .in_valid(in_valid),
        .in_top(in_top), .in_bot(in_bot), .in_ready(rdy_a), .en_wr(en_a),
        .wr_ptr(ptr_a), .wr_data(data_a), .stage_done(done_a)
    );

    wr_addr_generator #(.stage_FFT(4), .N(N), .SIZE(SIZE), .WIDTH(WIDTH)) dut_s4 (
        .clk(clk), .rst(rst), .start_stage(start_stage), .in_valid(in_valid),
        .in_top(in_top), .in_bot(in_bot), .in_ready(rdy_b), .en_wr(en_b),
        .wr_ptr(ptr_b), .wr_data(data_b), .stage_done(done_b)
    );

    typedef struct {
        int          cyc;
        int          p;
        logic [31:0] data;
        bit          bot;
    } wr_t;

    wr_t  q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   m_active = 1'b0;
    int   m_acc = 0;
    int   m_last_bot = 0;
    int   m_done_cyc = -1;
    int   w_cnt = 0;
    int   d_cnt = 0;
    bit   exp_rdy, exp_en;
    int   pa, pb, top;
    logic [31:0] ed;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int exp_addr(input int p, input int stage, input bit bot);
        int h;
        h = 1 << (stage - 1);
        return (p / h) * 2 * h + (p % h) + (bot ? h : 0);
    endfunction

    function automatic int pending();
        int n;
        n = 0;
        foreach (q[i]) if (!q[i].bot && q[i].cyc > cyc) n++;
        return n;
    endfunction

    // Reference model: pairs are written in arrival order, top no earlier than one
    // cycle after the handshake and no earlier than the cycle after the previous bottom.
    initial begin
        forever begin
            @(negedge clk);
            exp_rdy = m_active && (m_acc < NP) && (pending() < 2);
            check("in_ready_s2", 64'(rdy_a), 64'(exp_rdy));
            check("in_ready_s4", 64'(rdy_b), 64'(exp_rdy));
            exp_en = (q.size() > 0) && (q[0].cyc == cyc);
            if (exp_en) begin
                pa = exp_addr(q[0].p, 2, q[0].bot);
                pb = exp_addr(q[0].p, 4, q[0].bot);
                ed = q[0].data;
                void'(q.pop_front());
            end else begin
                pa = 0;
                pb = 0;
                ed = '0;
            end
            check("en_wr_s2", 64'(en_a), 64'(exp_en));
            check("wr_ptr_s2", 64'(ptr_a), 64'(pa));
            check("wr_data_s2", 64'(data_a), 64'(ed));
            check("en_wr_s4", 64'(en_b), 64'(exp_en));
            check("wr_ptr_s4", 64'(ptr_b), 64'(pb));
            check("wr_data_s4", 64'(data_b), 64'(ed));
            check("stage_done_s2", 64'(done_a), 64'(cyc == m_done_cyc));
            check("stage_done_s4", 64'(done_b), 64'(cyc == m_done_cyc));
            if (en_a)   w_cnt++;
            if (done_a) d_cnt++;
            if (rst) begin
                q.delete();
                m_active   = 1'b0;
                m_acc      = 0;
                m_done_cyc = -1;
            end else begin
                if (in_valid && exp_rdy) begin
                    top = (cyc + 1 > m_last_bot + 1) ? cyc + 1 : m_last_bot + 1;
                    q.push_back('{top, m_acc, in_top, 1'b0});
                    q.push_back('{top + 1, m_acc, in_bot, 1'b1});
                    m_last_bot = top + 1;
                    m_acc++;
                    if (m_acc == NP) m_done_cyc = m_last_bot + 1;
                end
                if (start_stage && !m_active) begin
                    m_active   = 1'b1;
                    m_acc      = 0;
                    m_last_bot = cyc;
                    m_done_cyc = -1;
                end else if (m_active && cyc == m_done_cyc) begin
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cycle(input int mode, input int k);
        case (mode)
            0:       in_valid = (k % 2 == 0);
            1:       in_valid = 1'b1;
            2:       in_valid = (k % 5 == 0);
            default: in_valid = 1'($urandom_range(0, 1));
        endcase
        in_top = $urandom;
        in_bot = $urandom;
    endtask

    task automatic run_stage(input int mode, input int stray_start_at, input int abort_after);
        int k;
        int budget;
        bit aborted;
        k       = 0;
        budget  = 400;
        aborted = 1'b0;
        in_valid    = 1'b0;
        start_stage = 1'b1;
        w_cnt = 0;
        d_cnt = 0;
        step();
        start_stage = 1'b0;
        while (m_active && budget > 0) begin
            drive_cycle(mode, k);
            start_stage = (k == stray_start_at);
            if (abort_after > 0 && m_acc >= abort_after) begin
                in_valid    = 1'b0;
                start_stage = 1'b0;
                rst         = 1'b1;
                step();
                rst     = 1'b0;
                aborted = 1'b1;
                break;
            end
            step();
            k++;
            budget--;
        end
        in_valid    = 1'b0;
        start_stage = 1'b0;
        if (budget == 0) begin
            check("stage_timeout", 64'(0), 64'(1));
        end else if (!aborted) begin
            check("write_count", 64'(w_cnt), 64'(2 * NP));
            check("done_count", 64'(d_cnt), 64'(1));
        end
    endtask

    initial begin
        rst         = 1'b1;
        start_stage = 1'b0;
        in_valid    = 1'b0;
        in_top      = '0;
        in_bot      = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        run_stage(0, -1, 0);
        step();
        run_stage(1, -1, 0);
        run_stage(2, -1, 0);
        run_stage(1, -1, 3);
        repeat (2) step();
        in_valid = 1'b1;
        repeat (4) begin
            in_top = $urandom;
            in_bot = $urandom;
            step();
        end
        in_valid = 1'b0;
        run_stage(3, 6, 0);
        repeat (6) run_stage(3, int'($urandom_range(0, 20)), 0);
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
